// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single shared memory bus.
// Optional FLASH_WAIT_EN: per-access wait count from the latched address.
module mem_arbiter #(
    parameter int SRAM_WAIT  = 1,
    parameter int FLASH_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        stall_req,
    output logic        bus_ce,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_nx;
    logic [3:0]  wait_load;
    logic        last_mem;
    logic        grant_mem;
    logic        lat_we;
    logic [3:0]  lat_sel;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        req_any;
    logic        pick_mem;
    logic [31:0] pick_addr;
    logic        grant;
    logic        capture;

    assign req_any   = if_req | mem_req;
    // mem has priority unless it won the previous grant
    assign pick_mem  = mem_req & (~if_req | ~last_mem);
    assign pick_addr = pick_mem ? mem_addr : if_addr;

`ifdef FLASH_WAIT_EN
    assign wait_load = (pick_addr[31:24] == 8'h1E) ? 4'(FLASH_WAIT)
                                                   : 4'(SRAM_WAIT);
`else
    logic [3:0] unused_flash_wait;
    assign unused_flash_wait = 4'(FLASH_WAIT);
    assign wait_load         = 4'(SRAM_WAIT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        grant    = 1'b0;
        capture  = 1'b0;
        if_ack   = 1'b0;
        mem_ack  = 1'b0;
        bus_ce   = 1'b0;
        bus_we   = 1'b0;
        bus_sel  = 4'd0;
        unique case (state)
            IDLE: begin
                if (req_any) begin
                    grant    = 1'b1;
                    wait_nx  = wait_load;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                bus_ce  = 1'b1;
                bus_we  = lat_we;
                bus_sel = lat_sel;
                if (wait_cnt == 4'd0) begin
                    capture  = ~lat_we;
                    state_nx = DONE;
                end else begin
                    wait_nx = wait_cnt - 4'd1;
                end
            end
            DONE: begin
                if_ack   = ~grant_mem;
                mem_ack  = grant_mem;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_mem  <= 1'b0;
            grant_mem <= 1'b0;
            lat_we    <= 1'b0;
            lat_sel   <= 4'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            if_rdata  <= 32'd0;
            mem_rdata <= 32'd0;
        end else begin
            if (grant) begin
                last_mem  <= pick_mem;
                grant_mem <= pick_mem;
                lat_addr  <= pick_addr;
                lat_we    <= pick_mem & mem_we;
                lat_sel   <= pick_mem ? mem_sel : 4'b1111;
                lat_wdata <= pick_mem ? mem_wdata : 32'd0;
            end
            if (capture) begin
                if (grant_mem) mem_rdata <= bus_rdata;
                else           if_rdata  <= bus_rdata;
            end
        end
    end

    assign bus_addr  = lat_addr;
    assign bus_wdata = lat_wdata;

    assign stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a timestamp-based transaction model.
// Build with +define+FLASH_WAIT_EN to exercise the flash wait-state path.
module tb_mem_arbiter;

    localparam int SW   = 1;
    localparam int FW   = 4;
    localparam int NCYC = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_sel = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_req;
    logic        bus_ce;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;

    mem_arbiter #(.SRAM_WAIT(SW), .FLASH_WAIT(FW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_req(stall_req),
        .bus_ce(bus_ce), .bus_we(bus_we), .bus_sel(bus_sel),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    endtask

    function automatic int wait_of(input logic [31:0] a);
`ifdef FLASH_WAIT_EN
        return (a[31:24] == 8'h1E) ? FW : SW;
`else
        return SW;
`endif
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(3) == 0) a[31:24] = 8'h1E;
        return a;
    endfunction

    // transaction model: one outstanding grant described by timestamps
    bit          granted = 0;
    int          g_start, g_w;
    bit          g_mem, g_we;
    logic [3:0]  g_sel;
    logic [31:0] g_addr, g_wdata;
    int          idle_at = 0;
    bit          last_mem = 0;
    logic [31:0] e_if_rd = '0, e_mem_rd = '0;
    bit          rst_prev = 0;
    int          n_rst = 0;
    bit          if_pend = 0, mem_pend = 0;
    logic [31:0] rd_hist [0:NCYC-1];

    initial begin
        bit e_if_ack, e_mem_ack, in_acc, rst_c, e_stall;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            cyc = c;
            e_if_ack  = granted && !g_mem && c == g_start + g_w + 2;
            e_mem_ack = granted &&  g_mem && c == g_start + g_w + 2;
            if (granted && c == g_start + g_w + 2 && !g_we) begin
                if (g_mem) e_mem_rd = rd_hist[g_start + g_w + 1];
                else       e_if_rd  = rd_hist[g_start + g_w + 1];
            end
            in_acc = granted && c >= g_start + 1 && c <= g_start + g_w + 1;

            if (c > 0) begin
                check("bus_ce", 32'(bus_ce), 32'(in_acc));
                check("bus_we", 32'(bus_we), 32'(in_acc && g_we));
                check("bus_sel", 32'(bus_sel), in_acc ? 32'(g_sel) : 32'd0);
                if (in_acc) check("bus_addr", bus_addr, g_addr);
                if (in_acc && g_we) check("bus_wdata", bus_wdata, g_wdata);
                if (rst_prev) begin
                    check("rst_addr", bus_addr, 32'd0);
                    check("rst_wdata", bus_wdata, 32'd0);
                end
                check("if_ack", 32'(if_ack), 32'(e_if_ack));
                check("mem_ack", 32'(mem_ack), 32'(e_mem_ack));
                check("if_rdata", if_rdata, e_if_rd);
                check("mem_rdata", mem_rdata, e_mem_rd);
            end
            if (granted && c == g_start + g_w + 2) granted = 0;

            // requesters: hold until ack, scramble addr/data while granted
            if (if_pend && e_if_ack) if_pend = 0;
            if (!if_pend && c >= 2 && $urandom_range(2) == 0) begin
                if_pend = 1;
                if_addr = rand_addr();
            end else if (if_pend && granted && !g_mem) begin
                if_addr = $urandom;
            end
            if_req = if_pend;

            if (mem_pend && e_mem_ack) mem_pend = 0;
            if (!mem_pend && c >= 2 && $urandom_range(2) == 0) begin
                mem_pend  = 1;
                mem_addr  = rand_addr();
                mem_we    = 1'($urandom_range(1));
                mem_sel   = 4'($urandom);
                mem_wdata = $urandom;
            end else if (mem_pend && granted && g_mem) begin
                mem_addr  = $urandom;
                mem_wdata = $urandom;
            end
            mem_req = mem_pend;

            rst_c = (c < 2) ||
                    (granted && c == g_start + 1 && n_rst < 6 &&
                     $urandom_range(4) == 0);
            rst = rst_c;
            bus_rdata  = $urandom;
            rd_hist[c] = bus_rdata;

            if (rst_c) begin
                if (c >= 2) n_rst++;
                granted  = 0;
                idle_at  = c + 1;
                last_mem = 0;
                e_if_rd  = '0;
                e_mem_rd = '0;
            end else if (c >= idle_at && (if_req || mem_req)) begin
                g_mem    = mem_req && (!if_req || !last_mem);
                last_mem = g_mem;
                granted  = 1;
                g_start  = c;
                g_addr   = g_mem ? mem_addr : if_addr;
                g_we     = g_mem ? mem_we : 1'b0;
                g_sel    = g_mem ? mem_sel : 4'b1111;
                g_wdata  = mem_wdata;
                g_w      = wait_of(g_addr);
                idle_at  = c + g_w + 3;
            end
            rst_prev = rst_c;

            #1;
            e_stall = (if_req && !e_if_ack) || (mem_req && !e_mem_ack);
            if (c > 0) check("stall_req", 32'(stall_req), 32'(e_stall));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
